// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
// Owns the data memory and performs the loads and stores addressed by ACIn.
// Holds the MEM/WB pipeline register that feeds write-back directly.
// A wait-state counter (MEM_WAIT, 0..3) models a slow memory and raises busy
// while an access is outstanding.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   stallIn           freeze: MEM/WB, counter and memory all hold
//   flush             synchronous squash (priority over stallIn)
//   validIn           execute presents an instruction
//   WRIn/RMIn/MRIn/MWIn, ACIn, storeData, rdIn   instruction fields
//   busy              stage is in a wait state; execute must hold
//   validOut, WR, RM, ACOUT, MEMOUT, rd           MEM/WB register to write-back
module mem_stage #(
  parameter int ADDR_W   = 8,
  parameter int MEM_WAIT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       stallIn,
  input  logic       flush,
  input  logic       validIn,
  input  logic       WRIn,
  input  logic       RMIn,
  input  logic       MRIn,
  input  logic       MWIn,
  input  logic [7:0] ACIn,
  input  logic [7:0] storeData,
  input  logic [1:0] rdIn,
  output logic       busy,
  output logic       validOut,
  output logic       WR,
  output logic       RM,
  output logic [7:0] ACOUT,
  output logic [7:0] MEMOUT,
  output logic [1:0] rd
);

  localparam logic [1:0] WAIT_CNT = 2'(MEM_WAIT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  typedef struct packed {
    logic       wr;
    logic       rm;
    logic       mr;
    logic       mw;
    logic [7:0] ac;
    logic [7:0] sd;
    logic [1:0] rd;
  } op_t;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  op_t        op_q, op_d;
  op_t        in_op, cop;      // cop: the op completing on this edge
  logic       accept, done, bubble, we;
  logic [ADDR_W-1:0] addr;
  logic [7:0] rdata;

  logic [7:0] mem_q [0:(1<<ADDR_W)-1];

  logic       valid_q, wr_q, rm_q;
  logic [7:0] ac_q, memout_q;
  logic [1:0] rd_q;

  always_comb begin
    in_op = '{wr: WRIn, rm: RMIn, mr: MRIn, mw: MWIn,
              ac: ACIn, sd: storeData, rd: rdIn};
  end

  assign accept = validIn & ~busy & ~stallIn & ~flush;

  // State register (also the latched instruction for a waiting access)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; also decides whether this edge completes or bubbles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done    = 1'b0;
    bubble  = 1'b0;
    cop     = in_op;
    case (state_q)
      IDLE: begin
        if (flush) begin
          bubble = 1'b1;
        end else if (!stallIn) begin
          if (accept && (!(in_op.mr | in_op.mw) || MEM_WAIT == 0)) begin
            done = 1'b1;
          end else if (accept) begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT;
            op_d    = in_op;
            bubble  = 1'b1;
          end else begin
            bubble = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          // abort: nothing is written
          state_d = IDLE;
          cnt_d   = 2'd0;
          bubble  = 1'b1;
        end else if (!stallIn) begin
          if (cnt_q == 2'd1) begin
            done    = 1'b1;
            cop     = op_q;
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d  = cnt_q - 2'd1;
            bubble = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == WAIT);
  end

  // Data memory: read is pre-edge contents; MR&MW together is a store.
  assign addr  = cop.ac[ADDR_W-1:0];
  assign rdata = mem_q[addr];
  assign we    = done & cop.mw;

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= cop.sd;
  end

  // MEM/WB register; a bubble clears only validOut and WR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      wr_q     <= 1'b0;
      rm_q     <= 1'b0;
      ac_q     <= 8'h00;
      memout_q <= 8'h00;
      rd_q     <= 2'd0;
    end else if (done) begin
      valid_q <= 1'b1;
      wr_q    <= cop.wr;
      rm_q    <= cop.rm;
      ac_q    <= cop.ac;
      rd_q    <= cop.rd;
      if (cop.mw)      memout_q <= cop.sd;
      else if (cop.mr) memout_q <= rdata;
    end else if (bubble) begin
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  assign validOut = valid_q;
  assign WR       = wr_q;
  assign RM       = rm_q;
  assign ACOUT    = ac_q;
  assign MEMOUT   = memout_q;
  assign rd       = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: four instances, one per MEM_WAIT value 0..3, each with
// its own stimulus. A transaction-level model tracks every instance all run.
module tb_mem_stage;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic       stall[4], flush[4], vin[4], wrin[4], rmin[4], mrin[4], mwin[4];
  logic [7:0] acin[4], sdin[4];
  logic [1:0] rdin[4];
  logic       busy_o[4], vout[4], wr_o[4], rm_o[4];
  logic [7:0] ac_o[4], mo_o[4];
  logic [1:0] rd_o[4];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_stage #(.ADDR_W(8), .MEM_WAIT(g)) u_dut (
      .clock(clock), .reset(rst_n), .stallIn(stall[g]), .flush(flush[g]),
      .validIn(vin[g]), .WRIn(wrin[g]), .RMIn(rmin[g]), .MRIn(mrin[g]),
      .MWIn(mwin[g]), .ACIn(acin[g]), .storeData(sdin[g]), .rdIn(rdin[g]),
      .busy(busy_o[g]), .validOut(vout[g]), .WR(wr_o[g]), .RM(rm_o[g]),
      .ACOUT(ac_o[g]), .MEMOUT(mo_o[g]), .rd(rd_o[g]));
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit       wr, rm, mr, mw;
    bit [7:0] ac, sd;
    bit [1:0] rd;
  } op_t;

  op_t      pop[4];
  bit       pend[4];
  int       rem[4];
  bit [7:0] mmem[4][256];
  bit       mknown[4][256];
  bit       e_v[4], e_wr[4], e_rm[4], e_moknown[4];
  bit [7:0] e_ac[4], e_mo[4];
  bit [1:0] e_rd[4];

  task automatic m_complete(input int k, input op_t o);
    e_v[k] = 1; e_wr[k] = o.wr; e_rm[k] = o.rm; e_ac[k] = o.ac; e_rd[k] = o.rd;
    if (o.mw) begin
      mmem[k][o.ac] = o.sd; mknown[k][o.ac] = 1; e_mo[k] = o.sd; e_moknown[k] = 1;
    end else if (o.mr) begin
      e_mo[k] = mmem[k][o.ac]; e_moknown[k] = mknown[k][o.ac];
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        pend[k] = 0; e_v[k] = 0; e_wr[k] = 0; e_rm[k] = 0;
        e_ac[k] = 0; e_mo[k] = 0; e_rd[k] = 0; e_moknown[k] = 1;
      end else if (flush[k]) begin
        pend[k] = 0; e_v[k] = 0; e_wr[k] = 0;
      end else if (!stall[k]) begin
        if (pend[k]) begin
          rem[k] = rem[k] - 1;
          if (rem[k] == 0) begin
            m_complete(k, pop[k]); pend[k] = 0;
          end else begin
            e_v[k] = 0; e_wr[k] = 0;
          end
        end else if (vin[k]) begin
          op_t o;
          o.wr = wrin[k]; o.rm = rmin[k]; o.mr = mrin[k]; o.mw = mwin[k];
          o.ac = acin[k]; o.sd = sdin[k]; o.rd = rdin[k];
          if (!(o.mr || o.mw) || k == 0) m_complete(k, o);
          else begin
            pop[k] = o; pend[k] = 1; rem[k] = k; e_v[k] = 0; e_wr[k] = 0;
          end
        end else begin
          e_v[k] = 0; e_wr[k] = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      stall[k] = 0; flush[k] = 0; vin[k] = 0; wrin[k] = 0; rmin[k] = 0;
      mrin[k] = 0; mwin[k] = 0; acin[k] = 0; sdin[k] = 0; rdin[k] = 0;
    end
  endtask

  task automatic set_op(input int k, input logic wr, rm, mr, mw,
                        input logic [7:0] ac, sd, input logic [1:0] rdv);
    vin[k] = 1; wrin[k] = wr; rmin[k] = rm; mrin[k] = mr; mwin[k] = mw;
    acin[k] = ac; sdin[k] = sd; rdin[k] = rdv;
  endtask

  // Issue one memory op on instance k from IDLE and wait for completion.
  task automatic do_op(input int k, input logic mr, mw,
                       input logic [7:0] ac, sd, output logic [7:0] mo);
    set_op(k, mr, mr, mr, mw, ac, sd, 2'd0);
    tick();
    vin[k] = 0;
    for (int i = 0; i < 8 && vout[k] !== 1'b1; i++) tick();
    n_vec++;
    if (vout[k] !== 1'b1) begin
      n_err++;
      $display("FAIL do_op_timeout k=%0d: validOut=%b want 1", k, vout[k]);
    end
    mo = mo_o[k];
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({busy_o[k], vout[k], wr_o[k], rm_o[k], ac_o[k], mo_o[k], rd_o[k]} !== 21'd0) begin
        n_err++;
        $display("FAIL reset k=%0d: got %b%b%b%b %h %h %0d want all zero", k,
                 busy_o[k], vout[k], wr_o[k], rm_o[k], ac_o[k], mo_o[k], rd_o[k]);
      end
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_nonmem();
    set_op(0, 1, 0, 0, 0, 8'h5A, 8'h00, 2'd2);
    tick();
    vin[0] = 0;
    n_vec++;
    if ({vout[0], wr_o[0], ac_o[0], rd_o[0]} !== {1'b1, 1'b1, 8'h5A, 2'd2}) begin
      n_err++;
      $display("FAIL nonmem: got v=%b wr=%b ac=%h rd=%0d want 1 1 5a 2",
               vout[0], wr_o[0], ac_o[0], rd_o[0]);
    end
    tick();
    n_vec++;
    if ({vout[0], wr_o[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL nonmem_bubble: got v=%b wr=%b want 0 0", vout[0], wr_o[0]);
    end
  endtask

  task automatic test_store_load();
    set_op(0, 0, 0, 0, 1, 8'h10, 8'hC3, 2'd0);
    tick();
    n_vec++;
    if ({vout[0], mo_o[0]} !== {1'b1, 8'hC3}) begin
      n_err++;
      $display("FAIL store0: got v=%b mo=%h want 1 c3", vout[0], mo_o[0]);
    end
    set_op(0, 1, 1, 1, 0, 8'h10, 8'h00, 2'd1);
    tick();
    vin[0] = 0;
    n_vec++;
    if ({vout[0], rm_o[0], mo_o[0]} !== {1'b1, 1'b1, 8'hC3}) begin
      n_err++;
      $display("FAIL load0: got v=%b rm=%b mo=%h want 1 1 c3", vout[0], rm_o[0], mo_o[0]);
    end
    tick();
  endtask

  task automatic test_wait2();
    logic [7:0] mo;
    do_op(2, 0, 1, 8'h10, 8'hC3, mo);
    set_op(2, 1, 1, 1, 0, 8'h10, 8'h00, 2'd1);
    tick();                                        // edge N: accept
    set_op(2, 1, 0, 0, 0, 8'h33, 8'h00, 2'd3);     // next instr held during busy
    n_vec++;
    if ({busy_o[2], vout[2]} !== 2'b10) begin
      n_err++; $display("FAIL w2_n: got busy=%b v=%b want 1 0", busy_o[2], vout[2]);
    end
    tick();                                        // N+1
    n_vec++;
    if ({busy_o[2], vout[2]} !== 2'b10) begin
      n_err++; $display("FAIL w2_n1: got busy=%b v=%b want 1 0", busy_o[2], vout[2]);
    end
    tick();                                        // N+2: load completes
    n_vec++;
    if ({busy_o[2], vout[2], rm_o[2], mo_o[2]} !== {1'b0, 1'b1, 1'b1, 8'hC3}) begin
      n_err++;
      $display("FAIL w2_n2: got busy=%b v=%b rm=%b mo=%h want 0 1 1 c3",
               busy_o[2], vout[2], rm_o[2], mo_o[2]);
    end
    tick();                                        // N+3: second instr accepted
    vin[2] = 0;
    n_vec++;
    if ({vout[2], ac_o[2], rd_o[2], mo_o[2]} !== {1'b1, 8'h33, 2'd3, 8'hC3}) begin
      n_err++;
      $display("FAIL w2_n3: got v=%b ac=%h rd=%0d mo=%h want 1 33 3 c3",
               vout[2], ac_o[2], rd_o[2], mo_o[2]);
    end
    tick();
    n_vec++;
    if (vout[2] !== 1'b0) begin
      n_err++; $display("FAIL w2_single: got v=%b want 0", vout[2]);
    end
  endtask

  task automatic test_flush();
    logic [7:0] mo;
    do_op(3, 0, 1, 8'h20, 8'h00, mo);
    set_op(3, 0, 0, 0, 1, 8'h20, 8'h77, 2'd0);
    tick();
    vin[3] = 0;
    n_vec++;
    if (busy_o[3] !== 1'b1) begin
      n_err++; $display("FAIL flush_accept: got busy=%b want 1", busy_o[3]);
    end
    flush[3] = 1;
    tick();
    flush[3] = 0;
    n_vec++;
    if ({busy_o[3], vout[3], wr_o[3]} !== 3'b000) begin
      n_err++;
      $display("FAIL flush: got busy=%b v=%b wr=%b want 0 0 0", busy_o[3], vout[3], wr_o[3]);
    end
    tick(); tick(); tick(); tick();
    do_op(3, 1, 0, 8'h20, 8'h00, mo);
    n_vec++;
    if (mo !== 8'h00) begin
      n_err++; $display("FAIL flush_nowrite: got mo=%h want 00", mo);
    end
  endtask

  task automatic test_stall();
    set_op(1, 1, 0, 0, 0, 8'hE1, 8'h00, 2'd1);
    tick();
    set_op(1, 0, 0, 0, 1, 8'h30, 8'h5C, 2'd0);
    tick();                                        // edge N: store accepted
    vin[1] = 0;
    stall[1] = 1;
    n_vec++;
    if ({busy_o[1], vout[1], ac_o[1]} !== {1'b1, 1'b0, 8'hE1}) begin
      n_err++;
      $display("FAIL stall_n: got busy=%b v=%b ac=%h want 1 0 e1", busy_o[1], vout[1], ac_o[1]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({busy_o[1], vout[1], ac_o[1]} !== {1'b1, 1'b0, 8'hE1}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got busy=%b v=%b ac=%h want 1 0 e1",
                 i, busy_o[1], vout[1], ac_o[1]);
      end
    end
    stall[1] = 0;
    tick();                                        // N+3: completion
    n_vec++;
    if ({busy_o[1], vout[1], ac_o[1], mo_o[1]} !== {1'b0, 1'b1, 8'h30, 8'h5C}) begin
      n_err++;
      $display("FAIL stall_done: got busy=%b v=%b ac=%h mo=%h want 0 1 30 5c",
               busy_o[1], vout[1], ac_o[1], mo_o[1]);
    end
    stall[1] = 1;
    tick();
    stall[1] = 0;
    n_vec++;
    if ({vout[1], mo_o[1]} !== {1'b1, 8'h5C}) begin
      n_err++; $display("FAIL stall_outhold: got v=%b mo=%h want 1 5c", vout[1], mo_o[1]);
    end
    tick();
    n_vec++;
    if (vout[1] !== 1'b0) begin
      n_err++; $display("FAIL stall_release: got v=%b want 0", vout[1]);
    end
  endtask

  task automatic test_reset_midwait();
    logic [7:0] mo;
    do_op(3, 0, 1, 8'h40, 8'h11, mo);
    set_op(3, 1, 1, 0, 1, 8'h40, 8'h99, 2'd3);
    tick();
    vin[3] = 0;
    tick();
    #2 rst_n = 0;
    #1;
    n_vec++;
    if ({busy_o[3], vout[3], wr_o[3], rm_o[3], ac_o[3], mo_o[3], rd_o[3]} !== 21'd0) begin
      n_err++;
      $display("FAIL async_reset: got %b%b%b%b %h %h %0d want all zero",
               busy_o[3], vout[3], wr_o[3], rm_o[3], ac_o[3], mo_o[3], rd_o[3]);
    end
    tick();
    rst_n = 1;
    tick();
    do_op(3, 1, 0, 8'h40, 8'h00, mo);
    n_vec++;
    if (mo !== 8'h11) begin
      n_err++; $display("FAIL reset_nowrite: got mo=%h want 11", mo);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        vin[k]   = ($urandom_range(0, 3) != 0);
        wrin[k]  = 1'($urandom);
        rmin[k]  = 1'($urandom);
        mrin[k]  = 1'($urandom);
        mwin[k]  = 1'($urandom);
        acin[k]  = ($urandom_range(0, 4) == 0) ? 8'h10 : 8'($urandom_range(0, 15));
        sdin[k]  = 8'($urandom);
        rdin[k]  = 2'($urandom);
        stall[k] = ($urandom_range(0, 7) == 0);
        flush[k] = ($urandom_range(0, 15) == 0);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if ({busy_o[k], vout[k], wr_o[k], rm_o[k], ac_o[k], rd_o[k]} !==
            {pend[k], e_v[k], e_wr[k], e_rm[k], e_ac[k], e_rd[k]}) begin
          n_err++;
          $display("FAIL rand c=%0d k=%0d: got b=%b v=%b wr=%b rm=%b ac=%h rd=%0d want %b %b %b %b %h %0d",
                   c, k, busy_o[k], vout[k], wr_o[k], rm_o[k], ac_o[k], rd_o[k],
                   pend[k], e_v[k], e_wr[k], e_rm[k], e_ac[k], e_rd[k]);
        end
        if (e_moknown[k]) begin
          n_vec++;
          if (mo_o[k] !== e_mo[k]) begin
            n_err++;
            $display("FAIL rand_memout c=%0d k=%0d: got %h want %h", c, k, mo_o[k], e_mo[k]);
          end
        end
      end
    end
    idle_all();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_store_load();
    test_wait2();
    test_flush();
    test_stall();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
